sysc_brk_trap_unit: RTL and testbench

SYSC_BRK_TRAP_UNIT -- requirements
Module: sysc_brk_trap_unit

---
 rtl/sysc_brk_trap_unit.sv | 183 ++++++++++++++++++
 tb/tb_sysc_brk_trap_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysc_brk_trap_unit.sv
// BREAK/SYSCALL trap capture unit: selects the oldest trapping slot of an issue group,
// waits for older ops to retire, then hands the trap to the CSR unit and counts it.
module sysc_brk_trap_unit #(
  parameter int ISSUE_W = 2,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16,
  localparam int SLOT_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ISSUE_W-1:0]      in_valid,
  input  logic [ISSUE_W*32-1:0]   in_instr,
  input  logic [ISSUE_W*PC_W-1:0] in_pc,
  output logic                    in_ready,
  output logic [ISSUE_W-1:0]      kill_mask,
  input  logic                    retire_empty,
  input  logic                    flush,
  output logic                    trap_valid,
  input  logic                    trap_ready,
  output logic [1:0]              trap_op,
  output logic [14:0]             trap_code,
  output logic [PC_W-1:0]         trap_pc,
  output logic [SLOT_W-1:0]       trap_slot,
  output logic                    stall_fe,
  output logic                    busy,
  output logic [CNT_W-1:0]        sysc_cnt,
  output logic [CNT_W-1:0]        brk_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_REQ   = 2'b10
  } state_e;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BRK  = 2'b01;
  localparam logic [1:0] OP_SYSC = 2'b10;

  function automatic logic [1:0] decode_op(input logic [31:0] instr);
    logic [1:0] op;
    if (instr[31:15] == 17'h00054) begin
      op = OP_BRK;
    end else if (instr[31:15] == 17'h00056) begin
      op = OP_SYSC;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

  state_e              state_q, state_d;
  logic [1:0]          op_q;
  logic [14:0]         code_q;
  logic [PC_W-1:0]     pc_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [CNT_W-1:0]    sysc_cnt_q, brk_cnt_q;

  logic                sel_found_s;
  logic [SLOT_W-1:0]   sel_slot_s;
  logic [1:0]          sel_op_s;
  logic [14:0]         sel_code_s;
  logic [PC_W-1:0]     sel_pc_s;
  logic [ISSUE_W-1:0]  younger_s;
  logic                capture_s;
  logic                handshake_s;

  // Oldest valid slot carrying BREAK or SYSCALL wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_slot_s  = '0;
    sel_op_s    = OP_NONE;
    sel_code_s  = 15'h0000;
    sel_pc_s    = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (!sel_found_s && in_valid[i] && (decode_op(in_instr[32*i +: 32]) != OP_NONE)) begin
        sel_found_s = 1'b1;
        sel_slot_s  = SLOT_W'(i);
        sel_op_s    = decode_op(in_instr[32*i +: 32]);
        sel_code_s  = in_instr[32*i +: 15];
        sel_pc_s    = in_pc[PC_W*i +: PC_W];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  always_comb begin
    younger_s = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      younger_s[j] = in_valid[j] && (SLOT_W'(j) > sel_slot_s);
    end
  end

  // Flush wins over accept and retire in IDLE/DRAIN but cannot cancel a posted request.
  always_comb begin
    state_d     = state_q;
    kill_mask   = '0;
    capture_s   = 1'b0;
    handshake_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if ((|in_valid) && sel_found_s) begin
          state_d   = ST_DRAIN;
          capture_s = 1'b1;
          kill_mask = younger_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (retire_empty) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_REQ: begin
        if (trap_ready) begin
          handshake_s = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers hold their last capture until the next accepted trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NONE;
      code_q <= 15'h0000;
      pc_q   <= '0;
      slot_q <= '0;
    end else if (capture_s) begin
      op_q   <= sel_op_s;
      code_q <= sel_code_s;
      pc_q   <= sel_pc_s;
      slot_q <= sel_slot_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sysc_cnt_q <= '0;
      brk_cnt_q  <= '0;
    end else if (handshake_s) begin
      if (op_q == OP_SYSC) begin
        sysc_cnt_q <= sysc_cnt_q + CNT_W'(1);
      end else if (op_q == OP_BRK) begin
        brk_cnt_q <= brk_cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign trap_valid = (state_q == ST_REQ);
  assign busy       = (state_q != ST_IDLE);
  assign stall_fe   = (state_q != ST_IDLE);
  assign trap_op    = op_q;
  assign trap_code  = code_q;
  assign trap_pc    = pc_q;
  assign trap_slot  = slot_q;
  assign sysc_cnt   = sysc_cnt_q;
  assign brk_cnt    = brk_cnt_q;

endmodule

// File: tb/tb_sysc_brk_trap_unit.sv
// Scoreboard bench for sysc_brk_trap_unit: a driver pushes expected traps at accept,
// an independent monitor checks every presented trap and the event counters.
module tb_sysc_brk_trap_unit;

  localparam int IW = 2;
  localparam int PW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] in_valid;
  logic [63:0]   in_instr;
  logic [63:0]   in_pc;
  logic          in_ready;
  logic [IW-1:0] kill_mask;
  logic          retire_empty, flush;
  logic          trap_valid, trap_ready;
  logic [1:0]    trap_op;
  logic [14:0]   trap_code;
  logic [PW-1:0] trap_pc;
  logic [0:0]    trap_slot;
  logic          stall_fe, busy;
  logic [CW-1:0] sysc_cnt, brk_cnt;

  sysc_brk_trap_unit #(.ISSUE_W(IW), .PC_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .kill_mask(kill_mask), .retire_empty(retire_empty), .flush(flush),
    .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_op(trap_op),
    .trap_code(trap_code), .trap_pc(trap_pc), .trap_slot(trap_slot),
    .stall_fe(stall_fe), .busy(busy), .sysc_cnt(sysc_cnt), .brk_cnt(brk_cnt));

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    int          code;
    logic [31:0] pc;
    int          slot;
  } trap_t;

  trap_t exp_q[$];
  int    exp_sysc = 0;
  int    exp_brk  = 0;
  int    checks   = 0;
  int    errors   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference decode straight from the opcode table: 1 = BREAK, 2 = SYSCALL.
  function automatic int ref_op(input logic [31:0] x);
    int hi;
    hi = int'(x >> 15);
    if (hi == 32'h54) return 1;
    if (hi == 32'h56) return 2;
    return 0;
  endfunction

  // Monitor: compares every presented trap against the scoreboard head, tracks counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_sysc = 0;
      exp_brk  = 0;
    end else begin
      chk("sysc_cnt", sysc_cnt, exp_sysc);
      chk("brk_cnt", brk_cnt, exp_brk);
      if (trap_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_trap", 1, 0);
        end else begin
          chk("trap_op", trap_op, exp_q[0].op);
          chk("trap_code", trap_code, exp_q[0].code);
          chk("trap_pc", trap_pc, exp_q[0].pc);
          chk("trap_slot", trap_slot, exp_q[0].slot);
          if (trap_ready) begin
            trap_t t;
            t = exp_q.pop_front();
            if (t.op == 2) exp_sysc = (exp_sysc + 1) % (1 << CW);
            if (t.op == 1) exp_brk  = (exp_brk + 1) % (1 << CW);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One issue group, starting and ending just after a rising edge.
  task automatic issue(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input int drain_d, input int ready_d,
                       input bit fl_idle, input bit fl_drain, input bit fl_req);
    logic [31:0] ins [2];
    logic [31:0] pcs [2];
    int          sel;
    logic [1:0]  expk;
    bit          take;
    ins[0] = i0; ins[1] = i1; pcs[0] = p0; pcs[1] = p1;
    sel = -1;
    for (int j = 0; j < 2; j++)
      if (sel < 0 && v[j] && ref_op(ins[j]) != 0) sel = j;
    take = (sel >= 0) && !fl_idle;
    expk = 2'b00;
    for (int j = 0; j < 2; j++)
      if (take && v[j] && j > sel) expk[j] = 1'b1;
    in_valid = v; in_instr = {i1, i0}; in_pc = {p1, p0};
    flush = fl_idle; retire_empty = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    chk("kill_mask", kill_mask, expk);
    if (take) begin
      trap_t t;
      t.op = ref_op(ins[sel]); t.code = int'(ins[sel][14:0]);
      t.pc = pcs[sel]; t.slot = sel;
      exp_q.push_back(t);
    end
    step();
    in_valid = 2'b00; flush = 1'b0;
    if (!take) begin
      @(negedge clk);
      chk("stays_idle", in_ready, 1);
      step();
      return;
    end
    for (int d = 0; d < drain_d; d++) begin
      @(negedge clk);
      chk("drain_busy", {busy, stall_fe, in_ready, trap_valid}, 4'b1100);
      step();
    end
    if (fl_drain) begin
      flush = 1'b1;
      @(negedge clk);
      chk("drain_no_trap", trap_valid, 0);
      void'(exp_q.pop_back());
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_to_idle", {in_ready, trap_valid}, 2'b10);
      step();
      return;
    end
    retire_empty = 1'b1;
    @(negedge clk);
    chk("drain_last", {trap_valid, in_ready}, 2'b00);
    step();
    retire_empty = 1'b0;
    flush = fl_req;
    @(negedge clk);
    chk("trap_valid_t2", trap_valid, 1);
    for (int r = 0; r < ready_d; r++) begin
      step();
      @(negedge clk);
      chk("req_hold", {trap_valid, in_ready}, 2'b10);
    end
    step();
    trap_ready = 1'b1;
    @(negedge clk);
    chk("req_at_hs", trap_valid, 1);
    step();
    trap_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_after_hs", {in_ready, trap_valid, busy}, 3'b100);
    step();
  endtask

  function automatic logic [31:0] rnd_instr();
    int k;
    k = $urandom_range(0, 2);
    if (k == 1) return {17'h00054, 15'($urandom)};
    if (k == 2) return {17'h00056, 15'($urandom)};
    return 32'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 2'b00; in_instr = 64'h0; in_pc = 64'h0;
    retire_empty = 1'b0; flush = 1'b0; trap_ready = 1'b0;
    @(negedge clk);
    chk("rst_payload", {trap_op, trap_code, trap_slot}, 18'h0);
    chk("rst_pc", trap_pc, 0);
    chk("rst_cnt", {sysc_cnt, brk_cnt}, 16'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", {in_ready, trap_valid, stall_fe, busy}, 4'b1000);
    step();

    issue(2'b11, 32'h00000033, 32'h002B0005, 32'h1000, 32'h1004, 0, 0, 0, 0, 0);
    chk("sysc_after_031", sysc_cnt, 1);
    issue(2'b11, 32'h002A0007, 32'h002B0001, 32'h2000, 32'h2004, 0, 1, 0, 0, 0);
    chk("brk_after_032", brk_cnt, 1);
    issue(2'b01, 32'h002A0003, 32'h0, 32'h3000, 32'h0, 5, 0, 0, 0, 0);
    issue(2'b10, 32'h0, 32'h002B0009, 32'h0, 32'h4004, 1, 0, 0, 1, 0);
    issue(2'b11, 32'h002B0011, 32'h00000013, 32'h5000, 32'h5004, 0, 2, 0, 0, 1);
    issue(2'b11, 32'h002A0001, 32'h002B0002, 32'h6000, 32'h6004, 0, 0, 1, 0, 0);
    issue(2'b00, 32'h002A0001, 32'h002B0002, 32'h6000, 32'h6004, 0, 0, 0, 0, 0);
    issue(2'b11, 32'h00000033, 32'h00000013, 32'h7000, 32'h7004, 0, 0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      issue(2'($urandom_range(0, 3)), rnd_instr(), rnd_instr(),
            32'($urandom) & 32'hFFFF_FFFC, 32'($urandom) & 32'hFFFF_FFFC,
            $urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 4) == 0));
    end

    // Walk brk_cnt up to all-ones, then one more BREAK must wrap it to zero.
    for (int n = 0; n < 300 && exp_brk != (1 << CW) - 1; n++)
      issue(2'b01, 32'h002A0000 | 32'(n & 32'h7FFF), 32'h0, 32'h8000, 32'h0, 0, 0, 0, 0, 0);
    chk("brk_all_ones", brk_cnt, 8'hFF);
    issue(2'b01, 32'h002A0055, 32'h0, 32'h9000, 32'h0, 0, 0, 0, 0, 0);
    chk("brk_wrap", brk_cnt, 8'h00);

    // Reset pulse while a request is posted.
    in_valid = 2'b01; in_instr = {32'h0, 32'h002B0044}; in_pc = {32'h0, 32'hA000};
    retire_empty = 1'b1;
    begin
      trap_t t;
      t.op = 2; t.code = 32'h44; t.pc = 32'hA000; t.slot = 0;
      exp_q.push_back(t);
    end
    step();
    in_valid = 2'b00;
    step();
    @(negedge clk);
    chk("pre_rst_req", trap_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", trap_valid, 0);
    chk("rst_async_cnt", {sysc_cnt, brk_cnt}, 16'h0);
    step();
    step();
    rst_n = 1'b1; retire_empty = 1'b0;
    @(negedge clk);
    chk("post_rst", {in_ready, busy, trap_valid}, 3'b100);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
